// File: rtl/pifo_port_arbiter.sv
// Front-end arbiter sharing a two-push / one-pop PIFO scheduler among N_REQ requesters and one consumer.
// Define PIFO_ARB_DUAL_PUSH_EN to allow two push grants per cycle; otherwise at most one.
module pifo_port_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_rank,
    input  logic [32*N_REQ-1:0]  req_value,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 deq_req,
    output logic                 deq_ready,
    output logic                 deq_valid,
    output logic [31:0]          deq_value,
    output logic                 sched_push_1,
    output logic [31:0]          sched_rank_1,
    output logic [31:0]          sched_value_1,
    output logic                 sched_push_2,
    output logic [31:0]          sched_rank_2,
    output logic [31:0]          sched_value_2,
    input  logic                 sched_can_push_1,
    input  logic                 sched_can_push_2,
    input  logic                 sched_can_pop,
    output logic                 sched_pop,
    input  logic [31:0]          sched_pop_value,
    input  logic                 sched_pop_valid
);

    localparam int unsigned PW = $clog2(N_REQ);

`ifdef PIFO_ARB_DUAL_PUSH_EN
    localparam bit DUAL_EN = 1'b1;
`else
    localparam bit DUAL_EN = 1'b0;
`endif

    typedef enum logic {
        PREFER_POP  = 1'b0,
        PREFER_PUSH = 1'b1
    } prefer_t;

    logic [PW-1:0] rr_ptr;
    prefer_t       prefer;
    logic          inflight;

    logic          c0_found, c1_found;
    logic [PW-1:0] c0_idx, c1_idx;
    logic          push_ok, pop_ok, contend;
    logic          push_go, pop_go, dual_go;
    logic [PW-1:0] last_idx, next_rr;
    logic          honour;

    function automatic logic [PW-1:0] scan_idx(input logic [PW-1:0] base, input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    // First and second requesters found walking circularly from rr_ptr.
    always_comb begin
        c0_found = 1'b0;
        c1_found = 1'b0;
        c0_idx   = '0;
        c1_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (req_valid[scan_idx(rr_ptr, k)]) begin
                if (!c0_found) begin
                    c0_found = 1'b1;
                    c0_idx   = scan_idx(rr_ptr, k);
                end else if (!c1_found) begin
                    c1_found = 1'b1;
                    c1_idx   = scan_idx(rr_ptr, k);
                end
            end
        end
    end

    always_comb begin
        push_ok = c0_found & sched_can_push_1;
        pop_ok  = deq_req & sched_can_pop;
        contend = push_ok & pop_ok;
        push_go = push_ok & (~pop_ok | (prefer == PREFER_PUSH));
        pop_go  = pop_ok & (~push_ok | (prefer == PREFER_POP));
        dual_go = DUAL_EN & push_go & c1_found & sched_can_push_2;
        honour  = inflight & sched_pop_valid;

        last_idx = dual_go ? c1_idx : c0_idx;
        if (32'(last_idx) == N_REQ - 1) next_rr = '0;
        else                            next_rr = last_idx + PW'(1);
    end

    // Every combinational output is held low while reset is asserted.
    always_comb begin
        req_ready     = '0;
        sched_push_1  = 1'b0;
        sched_rank_1  = '0;
        sched_value_1 = '0;
        sched_push_2  = 1'b0;
        sched_rank_2  = '0;
        sched_value_2 = '0;
        sched_pop     = 1'b0;
        deq_ready     = 1'b0;
        if (rst) begin
            if (push_go) begin
                req_ready[c0_idx] = 1'b1;
                sched_push_1      = 1'b1;
                sched_rank_1      = req_rank[{c0_idx, 5'b0} +: 32];
                sched_value_1     = req_value[{c0_idx, 5'b0} +: 32];
            end
            if (dual_go) begin
                req_ready[c1_idx] = 1'b1;
                sched_push_2      = 1'b1;
                sched_rank_2      = req_rank[{c1_idx, 5'b0} +: 32];
                sched_value_2     = req_value[{c1_idx, 5'b0} +: 32];
            end
            if (pop_go) begin
                sched_pop = 1'b1;
                deq_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr    <= '0;
            prefer    <= PREFER_POP;
            inflight  <= 1'b0;
            deq_valid <= 1'b0;
            deq_value <= '0;
        end else begin
            if (push_go) rr_ptr <= next_rr;
            if (contend) prefer <= (prefer == PREFER_POP) ? PREFER_PUSH : PREFER_POP;
            deq_valid <= honour;
            if (honour) deq_value <= sched_pop_value;
            // A new pop keeps the tracker armed even when a result retires this cycle.
            if (pop_go)      inflight <= 1'b1;
            else if (honour) inflight <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pifo_port_arbiter.sv
// Bench for pifo_port_arbiter: PIFO scheduler stub, queue-based reference model, directed and random stimulus.
module tb_pifo_port_arbiter;

    localparam int N    = 4;
    localparam int SIZE = 8;

`ifdef PIFO_ARB_DUAL_PUSH_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_rank, req_value;
    logic [N-1:0]      req_ready;
    logic              deq_req, deq_ready, deq_valid;
    logic [31:0]       deq_value;
    logic              sched_push_1, sched_push_2, sched_pop;
    logic [31:0]       sched_rank_1, sched_value_1, sched_rank_2, sched_value_2;
    logic              sched_can_push_1, sched_can_push_2, sched_can_pop;
    logic [31:0]       sched_pop_value;
    logic              sched_pop_valid;

    pifo_port_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rank(req_rank), .req_value(req_value), .req_ready(req_ready),
        .deq_req(deq_req), .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_value(deq_value),
        .sched_push_1(sched_push_1), .sched_rank_1(sched_rank_1), .sched_value_1(sched_value_1),
        .sched_push_2(sched_push_2), .sched_rank_2(sched_rank_2), .sched_value_2(sched_value_2),
        .sched_can_push_1(sched_can_push_1), .sched_can_push_2(sched_can_push_2),
        .sched_can_pop(sched_can_pop), .sched_pop(sched_pop),
        .sched_pop_value(sched_pop_value), .sched_pop_valid(sched_pop_valid)
    );

    // Scheduler stub: unbounded list, pops smallest rank, oldest first on ties.
    typedef struct { logic [31:0] rank; logic [31:0] value; } ent_t;
    typedef struct { int due; logic [31:0] value; } pend_t;
    ent_t  pq[$];
    pend_t pend[$];
    int    cnt_q = 0;
    bit    m_cp1 = 1, m_cp2 = 1, m_cp = 1, force_cp = 0, force_junk = 0, rand_junk = 0;

    assign sched_can_push_1 = (cnt_q < SIZE) && m_cp1;
    assign sched_can_push_2 = (cnt_q < SIZE - 1) && m_cp2;
    assign sched_can_pop    = force_cp || ((cnt_q > 0) && m_cp);

    function automatic logic [31:0] take(input bit remove);
        int b;
        logic [31:0] v;
        b = -1;
        for (int i = 0; i < pq.size(); i++)
            if (b < 0 || pq[i].rank < pq[b].rank) b = i;
        if (b < 0) return 32'hDEAD_BEEF;
        v = pq[b].value;
        if (remove) pq.delete(b);
        return v;
    endfunction

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    int          m_rr = 0;
    bit          m_prefer = 0;
    logic [31:0] m_last = '0;
    bit          e_push = 0, e_pop = 0, e_both = 0;
    int          e_last = 0;
    bit          d_push1 = 0, d_push2 = 0, d_pop = 0;
    logic [31:0] d_rank1, d_value1, d_rank2, d_value2;

    int          list[$];
    bit          push_ok, pop_ok, go_push, go_pop, go2, exp_dv;
    logic [N-1:0] exp_ready;

    always @(negedge clk) begin
        list = {};
        for (int k = 0; k < N; k++)
            if (req_valid[(m_rr + k) % N]) list.push_back((m_rr + k) % N);
        push_ok = rst && list.size() > 0 && sched_can_push_1;
        pop_ok  = rst && deq_req && sched_can_pop;
        go_push = push_ok && (!pop_ok || m_prefer);
        go_pop  = pop_ok && (!push_ok || !m_prefer);
        go2     = DUAL && go_push && list.size() > 1 && sched_can_push_2;
        exp_ready = '0;
        if (go_push) exp_ready[list[0]] = 1'b1;
        if (go2)     exp_ready[list[1]] = 1'b1;

        check("req_ready", req_ready, exp_ready);
        check("sched_push_1", sched_push_1, go_push);
        check("sched_push_2", sched_push_2, go2);
        check("sched_pop", sched_pop, go_pop);
        check("deq_ready", deq_ready, go_pop);
        check("mutex", sched_pop & sched_push_1, 0);
        if (go_push) begin
            check("rank_1", sched_rank_1, req_rank[32*list[0] +: 32]);
            check("value_1", sched_value_1, req_value[32*list[0] +: 32]);
        end
        if (go2) begin
            check("rank_2", sched_rank_2, req_rank[32*list[1] +: 32]);
            check("value_2", sched_value_2, req_value[32*list[1] +: 32]);
        end
        if (!rst) begin
            check("rst_rank_1", sched_rank_1, 0);
            check("rst_value_1", sched_value_1, 0);
            check("rst_rank_2", sched_rank_2, 0);
            check("rst_value_2", sched_value_2, 0);
        end

        exp_dv = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_dv = 1;
            m_last = pend[0].value;
            void'(pend.pop_front());
        end
        check("deq_valid", deq_valid, exp_dv);
        check("deq_value", deq_value, m_last);

        e_push = go_push; e_pop = go_pop; e_both = push_ok && pop_ok;
        e_last = go2 ? list[1] : (go_push ? list[0] : 0);
        d_push1 = sched_push_1; d_push2 = sched_push_2; d_pop = sched_pop;
        d_rank1 = sched_rank_1; d_value1 = sched_value_1;
        d_rank2 = sched_rank_2; d_value2 = sched_value_2;
    end

    always @(posedge clk) begin
        logic [31:0] v;
        if (!rst) begin
            m_rr = 0; m_prefer = 0; m_last = '0;
            pend.delete();
            pq.delete();
            sched_pop_valid <= force_junk;
            sched_pop_value <= 32'h0BAD_0BAD;
        end else begin
            if (e_pop)  pend.push_back('{due: cyc + 2, value: take(0)});
            if (e_push) m_rr = (e_last + 1) % N;
            if (e_both) m_prefer = !m_prefer;
            if (d_pop) begin
                v = take(1);
                sched_pop_valid <= 1'b1;
                sched_pop_value <= v;
            end else begin
                sched_pop_valid <= force_junk || (rand_junk && $urandom_range(7) == 0);
                sched_pop_value <= $urandom;
            end
            if (d_push1) pq.push_back('{rank: d_rank1, value: d_value1});
            if (d_push2) pq.push_back('{rank: d_rank2, value: d_value2});
        end
        cnt_q <= pq.size();
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0; deq_req = 0; force_cp = 0; force_junk = 0;
        m_cp1 = 1; m_cp2 = 1; m_cp = 1;
    endtask

    task automatic do_reset();
        step(); rst = 0; idle();
        step(); step();
        rst = 1;
    endtask

    task automatic dir_ranks();
        for (int i = 0; i < N; i++) begin
            req_rank[32*i +: 32]  = 32'(100 + i);
            req_value[32*i +: 32] = 32'(32'h1000 + i);
        end
    endtask

    initial begin
        rst = 0; idle(); dir_ranks();
        req_valid = 4'b1111; deq_req = 1; force_cp = 1;
        @(negedge clk);
        check("reset_req_ready", req_ready, 0);
        check("reset_sched_pop", sched_pop, 0);
        check("reset_deq_valid", deq_valid, 0);
        check("reset_deq_value", deq_value, 0);

        // Dual grant across the wrap point
        do_reset();
        step(); req_valid = 4'b0100;
        @(negedge clk); check("wrap_setup", req_ready, 4'b0100);
        step(); req_valid = 4'b1001;
        @(negedge clk);
        check("wrap_ready", req_ready, DUAL ? 4'b1001 : 4'b1000);
        check("wrap_rank_1", sched_rank_1, 32'd103);
        check("wrap_push_2", sched_push_2, DUAL);
        step(); req_valid = 4'b1111; m_cp2 = 0;
        @(negedge clk); check("wrap_next_rr", req_ready, DUAL ? 4'b0010 : 4'b0001);

        // Near-full: only port 1 usable
        do_reset();
        step(); req_valid = 4'b1111; m_cp2 = 0;
        @(negedge clk);
        check("nearfull_ready", req_ready, 4'b0001);
        check("nearfull_push_2", sched_push_2, 0);
        step();
        @(negedge clk); check("nearfull_rr", req_ready, 4'b0010);

        // Contention alternates pop, push, pop, push
        do_reset();
        step(); req_valid = 4'b0010; deq_req = 1; force_cp = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("contend_pop", sched_pop, (i % 2) == 0);
            check("contend_push", sched_push_1, (i % 2) == 1);
            if (i < 3) step();
        end
        step(); idle();

        // Round trip through the scheduler
        do_reset();
        step(); req_valid = 4'b0001; req_rank[31:0] = 32'd5; req_value[31:0] = 32'hA;
        step(); req_rank[31:0] = 32'd2; req_value[31:0] = 32'hB;
        step(); req_valid = '0; deq_req = 1;
        @(negedge clk); check("rt_pop_t0", sched_pop, 1);
        step();
        @(negedge clk); check("rt_pop_t1", sched_pop, 1);
        step(); deq_req = 0;
        @(negedge clk); check("rt_dv_t2", deq_valid, 1); check("rt_val_t2", deq_value, 32'hB);
        step();
        @(negedge clk); check("rt_dv_t3", deq_valid, 1); check("rt_val_t3", deq_value, 32'hA);
        step();
        @(negedge clk); check("rt_dv_t4", deq_valid, 0);

        // Reset while a pop is in flight, junk result right after release
        do_reset();
        step(); req_valid = 4'b0001; req_rank[31:0] = 32'd7; req_value[31:0] = 32'hC;
        step(); req_valid = '0; deq_req = 1;
        @(negedge clk); check("rstpop_pop", sched_pop, 1);
        step(); rst = 0; deq_req = 0; force_junk = 1;
        step(); rst = 1; force_junk = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstpop_dv", deq_valid, 0);
            check("rstpop_val", deq_value, 0);
            step();
        end

        // Two requesters: one or two grants per cycle depending on build
        do_reset(); dir_ranks();
        step(); req_valid = 4'b0011;
        @(negedge clk);
        check("single_first", req_ready, DUAL ? 4'b0011 : 4'b0001);
        check("single_push_2", sched_push_2, DUAL);
        step();
        @(negedge clk); check("single_second", req_ready, DUAL ? 4'b0011 : 4'b0010);

        // Randomized traffic against the model
        do_reset();
        rand_junk = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            rst       = ($urandom_range(299) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_rank[32*i +: 32]  = $urandom_range(63);
                req_value[32*i +: 32] = $urandom;
            end
            deq_req = ($urandom_range(2) != 0);
            m_cp1   = ($urandom_range(9) != 0);
            m_cp2   = ($urandom_range(5) != 0);
            m_cp    = ($urandom_range(9) != 0);
        end
        step(); idle();
        step();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
